// File: rtl/array_counter_pkg.sv
// -----------------------------------------------------------------------------
// array_counter_pkg
// Shared defaults and types for the counter-array arbiter.
//   DEF_W / DEF_N / DEF_IDW / DEF_R : default counter width, counter count,
//                                     counter id width, requester count
//   cnt_t   : one counter value
//   id_t    : one counter id
//   CNT_MAX : largest value a counter may hold
// -----------------------------------------------------------------------------
package array_counter_pkg;

    localparam int DEF_W   = 6;
    localparam int DEF_N   = 2;
    localparam int DEF_IDW = (DEF_N > 1) ? $clog2(DEF_N) : 1;
    localparam int DEF_R   = 4;

    typedef logic [DEF_W-1:0]   cnt_t;
    typedef logic [DEF_IDW-1:0] id_t;

    localparam cnt_t CNT_MAX = {DEF_W{1'b1}};

endpackage

// File: rtl/array_counter_arb_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin picker. Searches req starting at ptr, wrapping
// modulo R; the first set bit wins.
//   req      in  R   request vector (already qualified by the caller)
//   ptr      in  PW  requester with highest priority this cycle
//   gnt      out R   one-hot-or-zero grant
//   hit      out 1   a grant was issued
//   ptr_next out PW  pointer to load at the edge: winner+1 mod R, or ptr
// -----------------------------------------------------------------------------
module rr_arb #(
    parameter int R  = 4,
    parameter int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [R-1:0]  gnt,
    output logic          hit,
    output logic [PW-1:0] ptr_next
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt      = '0;
        hit      = 1'b0;
        ptr_next = ptr;
        idx      = '0;
        for (int k = 0; k < R; k++) begin
            idx = PW'((int'(ptr) + k) % R);
            if (!hit && req[idx]) begin
                hit      = 1'b1;
                gnt[idx] = 1'b1;
                ptr_next = PW'((int'(idx) + 1) % R);
            end
        end
    end

endmodule

// File: rtl/array_counter_arb.sv
// -----------------------------------------------------------------------------
// array_counter_arb
// Arbitrates R requesters onto a shared array of N W-bit counters that has a
// single increment port and a single decrement port. Each side has its own
// round-robin arbiter; requests that would overflow/underflow their target are
// refused using a projected count that includes the command currently being
// presented to the array.
//   clk, rst_n        clock, synchronous active-low reset
//   inc_req/_id       per-requester increment request and target counter
//   inc_gnt           one-hot-or-zero increment grant (combinational)
//   dec_req/_id       per-requester decrement request and target counter
//   dec_gnt           one-hot-or-zero decrement grant (combinational)
//   cnt               counter values read back from the array
//   rst               registered, active-high array reset
//   inc/inc_id        registered increment command to the array
//   dec/dec_id        registered decrement command to the array
// Handshake: a requester holds req until it sees gnt in the same cycle; in the
// following cycle it deasserts req or presents a new request (a held req is
// simply a new request).
// -----------------------------------------------------------------------------
module array_counter_arb
    import array_counter_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int N   = DEF_N,
    parameter int IDW = DEF_IDW,
    parameter int R   = DEF_R
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [R-1:0]          inc_req,
    input  logic [R-1:0][IDW-1:0] inc_req_id,
    output logic [R-1:0]          inc_gnt,
    input  logic [R-1:0]          dec_req,
    input  logic [R-1:0][IDW-1:0] dec_req_id,
    output logic [R-1:0]          dec_gnt,
    input  logic [N-1:0][W-1:0]   cnt,
    output logic                  rst,
    output logic                  inc,
    output logic [IDW-1:0]        inc_id,
    output logic                  dec,
    output logic [IDW-1:0]        dec_id
);

    localparam int         PW       = (R > 1) ? $clog2(R) : 1;
    localparam logic [W:0] PROJ_MAX = {1'b0, {W{1'b1}}};
    localparam logic [W:0] PROJ_ONE = {{W{1'b0}}, 1'b1};

    logic [W:0]     proj [N];
    logic [R-1:0]   inc_elig;
    logic [R-1:0]   dec_elig;
    logic           inc_hit;
    logic           dec_hit;
    logic [PW-1:0]  inc_ptr;
    logic [PW-1:0]  dec_ptr;
    logic [PW-1:0]  inc_ptr_next;
    logic [PW-1:0]  dec_ptr_next;
    logic [IDW-1:0] inc_sel_id;
    logic [IDW-1:0] dec_sel_id;

    // Count the array will hold once the command on inc/dec is absorbed.
    // One extra bit so the +1/-1 never wraps.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            proj[k] = {1'b0, cnt[k]};
            if (inc && inc_id == IDW'(k)) proj[k] = proj[k] + PROJ_ONE;
            if (dec && dec_id == IDW'(k)) proj[k] = proj[k] - PROJ_ONE;
        end
    end

    // Matching against every valid id means an id >= N never qualifies.
    // The same-cycle grant on the opposite side is deliberately not credited.
    always_comb begin
        inc_elig = '0;
        dec_elig = '0;
        for (int i = 0; i < R; i++) begin
            for (int k = 0; k < N; k++) begin
                if (inc_req[i] && inc_req_id[i] == IDW'(k) && proj[k] != PROJ_MAX)
                    inc_elig[i] = 1'b1;
                if (dec_req[i] && dec_req_id[i] == IDW'(k) && proj[k] != '0)
                    dec_elig[i] = 1'b1;
            end
        end
        // No grants while reset is requested or still held on the array.
        if (!rst_n || rst) begin
            inc_elig = '0;
            dec_elig = '0;
        end
    end

    rr_arb #(.R(R), .PW(PW)) u_inc_arb (
        .req      (inc_elig),
        .ptr      (inc_ptr),
        .gnt      (inc_gnt),
        .hit      (inc_hit),
        .ptr_next (inc_ptr_next)
    );

    rr_arb #(.R(R), .PW(PW)) u_dec_arb (
        .req      (dec_elig),
        .ptr      (dec_ptr),
        .gnt      (dec_gnt),
        .hit      (dec_hit),
        .ptr_next (dec_ptr_next)
    );

    always_comb begin
        inc_sel_id = '0;
        dec_sel_id = '0;
        for (int i = 0; i < R; i++) begin
            if (inc_gnt[i]) inc_sel_id = inc_req_id[i];
            if (dec_gnt[i]) dec_sel_id = dec_req_id[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst     <= 1'b1;
            inc     <= 1'b0;
            inc_id  <= '0;
            dec     <= 1'b0;
            dec_id  <= '0;
            inc_ptr <= '0;
            dec_ptr <= '0;
        end else begin
            rst <= 1'b0;
            inc <= inc_hit;
            dec <= dec_hit;
            if (inc_hit) begin
                inc_id  <= inc_sel_id;
                inc_ptr <= inc_ptr_next;
            end
            if (dec_hit) begin
                dec_id  <= dec_sel_id;
                dec_ptr <= dec_ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_array_counter_arb.sv
// -----------------------------------------------------------------------------
// tb_array_counter_arb
// Bench for array_counter_arb. Holds a behavioural counter array driven by the
// DUT's rst/inc/dec outputs (with a preload hook), and checks grants, the
// registered commands (via expected queues) and resulting counter values.
// -----------------------------------------------------------------------------
module tb_array_counter_arb;
    import array_counter_pkg::*;

    localparam int W   = DEF_W;
    localparam int N   = DEF_N;
    localparam int IDW = DEF_IDW;
    localparam int R   = DEF_R;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [R-1:0]          inc_req;
    logic [R-1:0][IDW-1:0] inc_req_id;
    logic [R-1:0]          inc_gnt;
    logic [R-1:0]          dec_req;
    logic [R-1:0][IDW-1:0] dec_req_id;
    logic [R-1:0]          dec_gnt;
    logic [N-1:0][W-1:0]   arr;
    logic                  rst;
    logic                  inc;
    id_t                   inc_id;
    logic                  dec;
    id_t                   dec_id;

    logic                  preload_en;
    int                    preload_idx;
    cnt_t                  preload_val;

    logic [IDW:0]          inc_q[$];
    logic [IDW:0]          dec_q[$];
    logic [IDW:0]          exp_cmd;
    logic [R-1:0]          exp_gnt;
    int                    tests_run;
    int                    tests_failed;

    always #5 clk = ~clk;

    array_counter_arb #(.W(W), .N(N), .IDW(IDW), .R(R)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_req    (inc_req),
        .inc_req_id (inc_req_id),
        .inc_gnt    (inc_gnt),
        .dec_req    (dec_req),
        .dec_req_id (dec_req_id),
        .dec_gnt    (dec_gnt),
        .cnt        (arr),
        .rst        (rst),
        .inc        (inc),
        .inc_id     (inc_id),
        .dec        (dec),
        .dec_id     (dec_id)
    );

    // Behavioural counter array.
    always @(posedge clk) begin
        if (rst) begin
            arr <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (preload_en && preload_idx == k)
                    arr[k] <= preload_val;
                else
                    arr[k] <= arr[k] + W'(inc && inc_id == id_t'(k)) - W'(dec && dec_id == id_t'(k));
            end
        end
    end

    task automatic clear_inputs();
        inc_req    = '0;
        dec_req    = '0;
        inc_req_id = '0;
        dec_req_id = '0;
    endtask

    // Leaves the bench just after the edge at which rst dropped; array is 0.
    task automatic do_reset();
        clear_inputs();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        inc_q.delete();
        dec_q.delete();
    endtask

    task automatic preload(input int idx, input cnt_t val);
        preload_en  = 1'b1;
        preload_idx = idx;
        preload_val = val;
        @(posedge clk); #1 preload_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        preload_en = 1'b0;
        inc_req    = '1;
        dec_req    = '1;
        inc_req_id = '0;
        dec_req_id = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (inc_gnt !== '0 || dec_gnt !== '0) begin
                tests_failed++;
                $display("FAIL reset_gnt c=%0d: inc_gnt=%b dec_gnt=%b want 0", c, inc_gnt, dec_gnt);
            end
            tests_run++;
            if ({rst, inc, dec, inc_id, dec_id} !== {3'b100, id_t'(0), id_t'(0)}) begin
                tests_failed++;
                $display("FAIL reset_outs c=%0d: rst=%b inc=%b dec=%b inc_id=%0d dec_id=%0d want 1,0,0,0,0",
                         c, rst, inc, dec, inc_id, dec_id);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rst !== 1'b1 || inc_gnt !== '0 || dec_gnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: rst=%b inc_gnt=%b dec_gnt=%b want 1,0,0", rst, inc_gnt, dec_gnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (rst !== 1'b0 || inc_gnt !== 4'b0001 || dec_gnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_first_gnt: rst=%b inc_gnt=%b dec_gnt=%b want 0,0001,0000", rst, inc_gnt, dec_gnt);
        end
        inc_q.push_back({1'b1, id_t'(0)});
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        exp_cmd = inc_q.pop_front();
        tests_run++;
        if ({inc, inc_id} !== exp_cmd) begin
            tests_failed++;
            $display("FAIL reset_first_cmd: inc,id=%b want %b", {inc, inc_id}, exp_cmd);
        end
    endtask

    task automatic test_round_robin();
        int exp_cnt;
        do_reset();
        inc_req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_gnt = R'(1) << (c % R);
            tests_run++;
            if (inc_gnt !== exp_gnt) begin
                tests_failed++;
                $display("FAIL rr_gnt c=%0d: got %b want %b", c, inc_gnt, exp_gnt);
            end
            exp_cnt = (c >= 1) ? c - 1 : 0;
            tests_run++;
            if (arr[0] !== W'(exp_cnt)) begin
                tests_failed++;
                $display("FAIL rr_cnt c=%0d: got %0d want %0d", c, arr[0], exp_cnt);
            end
            if (c >= 1) begin
                exp_cmd = inc_q.pop_front();
                tests_run++;
                if ({inc, inc_id} !== exp_cmd) begin
                    tests_failed++;
                    $display("FAIL rr_cmd c=%0d: inc,id=%b want %b", c, {inc, inc_id}, exp_cmd);
                end
            end
            inc_q.push_back({1'b1, id_t'(0)});
            @(posedge clk); #1;
        end
        inc_req = '0;
        @(negedge clk);
        exp_cmd = inc_q.pop_front();
        tests_run++;
        if ({inc, inc_id} !== exp_cmd) begin
            tests_failed++;
            $display("FAIL rr_last_cmd: inc,id=%b want %b", {inc, inc_id}, exp_cmd);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (arr[0] !== W'(5)) begin
            tests_failed++;
            $display("FAIL rr_final_cnt: got %0d want 5", arr[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        preload(1, cnt_t'(62));
        inc_req       = 4'b0100;
        inc_req_id[2] = 1'b1;
        @(negedge clk);
        tests_run++;
        if (inc_gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL sat_first_gnt: got %b want 0100", inc_gnt);
        end
        inc_q.push_back({1'b1, id_t'(1)});
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (inc_gnt !== '0) begin
            tests_failed++;
            $display("FAIL sat_proj_refuse: got %b want 0000", inc_gnt);
        end
        exp_cmd = inc_q.pop_front();
        tests_run++;
        if ({inc, inc_id} !== exp_cmd) begin
            tests_failed++;
            $display("FAIL sat_cmd: inc,id=%b want %b", {inc, inc_id}, exp_cmd);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (inc_gnt !== '0 || inc !== 1'b0 || arr[1] !== cnt_t'(63)) begin
                tests_failed++;
                $display("FAIL sat_hold c=%0d: inc_gnt=%b inc=%b cnt1=%0d want 0000,0,63", c, inc_gnt, inc, arr[1]);
            end
            @(posedge clk); #1;
        end
        dec_req       = 4'b0001;
        dec_req_id[0] = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dec_gnt !== 4'b0001 || inc_gnt !== '0) begin
            tests_failed++;
            $display("FAIL sat_dec_gnt: dec_gnt=%b inc_gnt=%b want 0001,0000", dec_gnt, inc_gnt);
        end
        dec_q.push_back({1'b1, id_t'(1)});
        @(posedge clk); #1 dec_req = '0;
        @(negedge clk);
        exp_cmd = dec_q.pop_front();
        tests_run++;
        if ({dec, dec_id} !== exp_cmd) begin
            tests_failed++;
            $display("FAIL sat_dec_cmd: dec,id=%b want %b", {dec, dec_id}, exp_cmd);
        end
        tests_run++;
        if (inc_gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL sat_resume: got %b want 0100", inc_gnt);
        end
        inc_q.push_back({1'b1, id_t'(1)});
        @(posedge clk); #1 inc_req = '0;
        @(negedge clk);
        exp_cmd = inc_q.pop_front();
        tests_run++;
        if ({inc, inc_id} !== exp_cmd || arr[1] !== cnt_t'(62)) begin
            tests_failed++;
            $display("FAIL sat_resume_cmd: inc,id=%b cnt1=%0d want %b,62", {inc, inc_id}, arr[1], exp_cmd);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (arr[1] !== cnt_t'(63)) begin
            tests_failed++;
            $display("FAIL sat_final_cnt: got %0d want 63", arr[1]);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        dec_req       = 4'b0010;
        dec_req_id[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (dec_gnt !== '0) begin
                tests_failed++;
                $display("FAIL uf_refuse c=%0d: got %b want 0000", c, dec_gnt);
            end
            @(posedge clk); #1;
        end
        inc_req       = 4'b0001;
        inc_req_id[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (inc_gnt !== 4'b0001 || dec_gnt !== '0) begin
            tests_failed++;
            $display("FAIL uf_inc: inc_gnt=%b dec_gnt=%b want 0001,0000", inc_gnt, dec_gnt);
        end
        @(posedge clk); #1 inc_req = '0;
        @(negedge clk);
        tests_run++;
        if (dec_gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL uf_one_dec: got %b want 0010", dec_gnt);
        end
        dec_q.push_back({1'b1, id_t'(0)});
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (dec_gnt !== '0) begin
                tests_failed++;
                $display("FAIL uf_refuse_again c=%0d: got %b want 0000", c, dec_gnt);
            end
            if (c == 0) begin
                exp_cmd = dec_q.pop_front();
                tests_run++;
                if ({dec, dec_id} !== exp_cmd) begin
                    tests_failed++;
                    $display("FAIL uf_dec_cmd: dec,id=%b want %b", {dec, dec_id}, exp_cmd);
                end
            end
            @(posedge clk); #1;
        end
        dec_req = '0;
        @(negedge clk);
        tests_run++;
        if (arr[0] !== '0) begin
            tests_failed++;
            $display("FAIL uf_final_cnt: got %0d want 0", arr[0]);
        end
    endtask

    task automatic test_collision();
        do_reset();
        preload(0, cnt_t'(10));
        inc_req       = 4'b0001;
        inc_req_id[0] = 1'b0;
        dec_req       = 4'b1000;
        dec_req_id[3] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (inc_gnt !== 4'b0001 || dec_gnt !== 4'b1000) begin
            tests_failed++;
            $display("FAIL coll_gnt: inc_gnt=%b dec_gnt=%b want 0001,1000", inc_gnt, dec_gnt);
        end
        inc_q.push_back({1'b1, id_t'(0)});
        dec_q.push_back({1'b1, id_t'(0)});
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        exp_cmd = inc_q.pop_front();
        tests_run++;
        if ({inc, inc_id} !== exp_cmd) begin
            tests_failed++;
            $display("FAIL coll_inc_cmd: inc,id=%b want %b", {inc, inc_id}, exp_cmd);
        end
        exp_cmd = dec_q.pop_front();
        tests_run++;
        if ({dec, dec_id} !== exp_cmd) begin
            tests_failed++;
            $display("FAIL coll_dec_cmd: dec,id=%b want %b", {dec, dec_id}, exp_cmd);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (arr[0] !== cnt_t'(10)) begin
            tests_failed++;
            $display("FAIL coll_cnt: got %0d want 10", arr[0]);
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        preload(1, cnt_t'(5));
        inc_req    = 4'b1111;
        inc_req_id = '0;
        dec_req    = 4'b1111;
        dec_req_id = '1;
        @(negedge clk);
        tests_run++;
        if (inc_gnt !== 4'b0001 || dec_gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_gnt: inc_gnt=%b dec_gnt=%b want 0001,0001", inc_gnt, dec_gnt);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (inc_gnt !== '0 || dec_gnt !== '0 || inc !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_block: inc_gnt=%b dec_gnt=%b inc=%b want 0000,0000,1", inc_gnt, dec_gnt, inc);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (inc !== 1'b0 || dec !== 1'b0 || rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_clear: inc=%b dec=%b rst=%b want 0,0,1", inc, dec, rst);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (arr !== '0) begin
            tests_failed++;
            $display("FAIL mid_cnt: got %h want 0", arr);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(posedge clk); #1;
        preload(1, cnt_t'(5));
        inc_req    = 4'b1111;
        inc_req_id = '0;
        dec_req    = 4'b1111;
        dec_req_id = '1;
        @(negedge clk);
        tests_run++;
        if (inc_gnt !== 4'b0001 || dec_gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_ptr_reset: inc_gnt=%b dec_gnt=%b want 0001,0001", inc_gnt, dec_gnt);
        end
        @(posedge clk); #1 clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        preload_en   = 1'b0;
        preload_idx  = 0;
        preload_val  = '0;
        test_reset();
        test_round_robin();
        test_saturation();
        test_underflow();
        test_collision();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
